multicycle_cu: RTL



---
 rtl/multicycle_cu.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_cu.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/writeback
// with wait-state memory handshaking, optional bus timeout and illegal-opcode trapping.
module multicycle_cu #(
    parameter int MAX_WAIT = 15,
    parameter bit TRAP_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func210,
    input  logic       func7,
    input  logic       branchtrue,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_ifetch,
    output logic       mem_we,
    output logic       ir_en,
    output logic       pc_en,
    output logic [2:0] pcsel,
    output logic       jalr,
    output logic       bands,
    output logic       opB,
    output logic       writeback,
    output logic       memwrite,
    output logic [1:0] opA,
    output logic [1:0] immsel,
    output logic [3:0] alucontrol,
    output logic       regfile,
    output logic       illegal,
    output logic       bus_err,
    output logic       retired
);

    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] CMAX = CW'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_IMM, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD
    } cls_t;

    state_t          state, state_nx;
    cls_t            cls_q, cls_in;
    logic [2:0]      f3_q;
    logic            f7_q;
    logic            trap_ill_q;
    logic [CW-1:0]   cnt_q;
    logic            in_mem, timeout;

    function automatic cls_t classify(input logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_IMM;
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b1100011: return C_BR;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            default:    return C_BAD;
        endcase
    endfunction

    // SUB only exists for register-register ops; SRA/SRAI both key off func7.
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7, input logic r_type);
        case (f3)
            3'b000:  return (r_type && f7) ? 4'b0001 : 4'b0000;
            3'b001:  return 4'b0111;
            3'b010:  return 4'b1000;
            3'b011:  return 4'b1001;
            3'b100:  return 4'b0100;
            3'b101:  return f7 ? 4'b0110 : 4'b0101;
            3'b110:  return 4'b0011;
            default: return 4'b0010;
        endcase
    endfunction

    assign cls_in  = classify(opcode);
    assign in_mem  = (state == S_FETCH) || (state == S_MEM);
    assign timeout = (MAX_WAIT != 0) && in_mem && !mem_ready && (cnt_q == CMAX);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = S_FETCH;
            S_FETCH:  if (timeout) state_nx = S_TRAP;
                      else if (mem_ready) state_nx = S_DECODE;
            S_DECODE: if (cls_in == C_BAD) state_nx = TRAP_EN ? S_TRAP : S_FETCH;
                      else state_nx = S_EXEC;
            S_EXEC:   if (cls_q == C_BR) state_nx = S_FETCH;
                      else if (cls_q == C_LOAD || cls_q == C_STORE) state_nx = S_MEM;
                      else state_nx = S_WB;
            S_MEM:    if (timeout) state_nx = S_TRAP;
                      else if (mem_ready) state_nx = (cls_q == C_STORE) ? S_FETCH : S_WB;
            S_WB:     state_nx = S_FETCH;
            S_TRAP:   state_nx = S_FETCH;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cls_q      <= C_R;
            f3_q       <= 3'b000;
            f7_q       <= 1'b0;
            trap_ill_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) begin
                cls_q <= cls_in;
                f3_q  <= func210;
                f7_q  <= func7;
            end
            if (state_nx == S_TRAP)
                trap_ill_q <= (state == S_DECODE);
            // Any state change clears the wait counter, so FETCH/MEM always start from zero.
            if (state_nx != state)
                cnt_q <= '0;
            else if (in_mem && !mem_ready && cnt_q != CMAX)
                cnt_q <= cnt_q + CW'(1);
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_ifetch = 1'b0;
        mem_we     = 1'b0;
        ir_en      = 1'b0;
        pc_en      = 1'b0;
        pcsel      = 3'b000;
        jalr       = 1'b0;
        bands      = 1'b0;
        opB        = 1'b0;
        writeback  = 1'b0;
        memwrite   = 1'b0;
        opA        = 2'b00;
        immsel     = 2'b00;
        alucontrol = 4'b0000;
        regfile    = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        retired    = 1'b0;

        // Operand/ALU selects stay valid through MEM and WB: the datapath has no ALU result register.
        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            case (cls_q)
                C_R:     begin opA = 2'b01; immsel = 2'b11; alucontrol = alu_op(f3_q, f7_q, 1'b1); end
                C_IMM:   begin opA = 2'b01; opB = 1'b1; immsel = 2'b00; alucontrol = alu_op(f3_q, f7_q, 1'b0); end
                C_LOAD,
                C_JALR:  begin opA = 2'b01; opB = 1'b1; immsel = 2'b00; alucontrol = 4'b0000; end
                C_STORE: begin opA = 2'b01; opB = 1'b1; immsel = 2'b01; alucontrol = 4'b0000; end
                C_BR:    begin opA = 2'b01; immsel = 2'b11; alucontrol = 4'b1111; bands = 1'b1; end
                C_JAL:   begin opA = 2'b00; immsel = 2'b11; alucontrol = 4'b1111; end
                C_LUI:   begin opA = 2'b11; opB = 1'b1; immsel = 2'b10; alucontrol = 4'b1110; end
                C_AUIPC: begin opA = 2'b10; opB = 1'b1; immsel = 2'b10; alucontrol = 4'b0000; end
                default: ;
            endcase
        end

        case (state)
            S_FETCH: begin
                if (timeout) bus_err = 1'b1;
                else begin
                    mem_req    = 1'b1;
                    mem_ifetch = 1'b1;
                    ir_en      = mem_ready;
                end
            end
            S_DECODE: begin
                if (cls_in == C_BAD && !TRAP_EN) begin
                    pc_en   = 1'b1;
                    retired = 1'b1;
                end
            end
            S_EXEC: begin
                if (cls_q == C_BR) begin
                    pc_en   = 1'b1;
                    retired = 1'b1;
                    pcsel   = branchtrue ? 3'b001 : 3'b000;
                end
            end
            S_MEM: begin
                if (timeout) bus_err = 1'b1;
                else begin
                    mem_req  = 1'b1;
                    mem_we   = (cls_q == C_STORE);
                    memwrite = (cls_q == C_STORE);
                    if (mem_ready && cls_q == C_STORE) begin
                        pc_en   = 1'b1;
                        retired = 1'b1;
                    end
                end
            end
            S_WB: begin
                regfile   = 1'b1;
                writeback = (cls_q == C_LOAD);
                pc_en     = 1'b1;
                retired   = 1'b1;
                jalr      = (cls_q == C_JALR);
                if (cls_q == C_JAL)       pcsel = 3'b010;
                else if (cls_q == C_JALR) pcsel = 3'b011;
            end
            S_TRAP: begin
                illegal = trap_ill_q;
                pc_en   = 1'b1;
                pcsel   = 3'b100;
            end
            default: ;
        endcase
    end

endmodule
